// File: rtl/aurora_enc_pkg.sv
// Shared definitions for the Aurora encoder word unpacker: field offsets inside
// the 64-bit encoder word, scan FSM encoding and statistics counter width.
package aurora_enc_pkg;

  // Bit offsets of the two position fields inside an encoder word.
  localparam int unsigned X_LSB = 0;
  localparam int unsigned W_LSB = 32;

  // Default width of the saturating statistics counters.
  localparam int unsigned CNT_W = 32;

  // Scan state machine.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAlign = 2'd1,
    StRun   = 2'd2,
    StFlush = 2'd3
  } state_e;

endpackage

// File: rtl/aurora_enc_skid_buf.sv
// Two-entry valid/ready buffer for the unpacker output stream. A push that
// finds the buffer full with no pop in the same cycle is rejected and flagged
// through push_ovf.
module aurora_enc_skid_buf #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ovf,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_q;
  logic             rd_q;
  logic [1:0]       cnt_q;
  logic             pop;
  logic             full;
  logic             push_ok;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rd_q];
  assign pop       = out_valid && out_ready;
  assign full      = (cnt_q == 2'd2);
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok   = push && (!full || pop);
  assign push_ovf  = push && full && !pop;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + {1'b0, push_ok} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/aurora_enc_unpack.sv
// Aurora encoder word unpacker (clk_100m side). Splits encoder words into X/W
// positions, decimates, checks W continuity and streams kept samples out over
// AXI-Stream through a two-entry skid buffer, with saturating statistics.
// Optional build macro AURORA_ENC_UNPACK_TLAST_EN: each kept word is parked in
// a holding register so the last word of a scan can carry m_axis_tlast.
module aurora_enc_unpack
  import aurora_enc_pkg::*;
#(
  parameter int unsigned DATA_WD = 64,
  parameter int unsigned POS_WD  = 32,
  parameter int unsigned CNT_WD  = CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_clr,
  input  logic [15:0]        cfg_dec_num,
  input  logic [31:0]        cfg_max_step,
  input  logic               enc_sop,
  input  logic               enc_eop,
  input  logic               enc_vld,
  input  logic [DATA_WD-1:0] enc_data,
  output logic [DATA_WD-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               busy,
  output logic [CNT_WD-1:0]  word_cnt,
  output logic [CNT_WD-1:0]  step_err_cnt,
  output logic [CNT_WD-1:0]  drop_cnt
);

`ifdef AURORA_ENC_UNPACK_TLAST_EN
  localparam int unsigned SkidWd = DATA_WD + 1;
`else
  localparam int unsigned SkidWd = DATA_WD;
`endif

  // S1 input register
  logic               s1_vld, s1_sop, s1_eop;
  logic [DATA_WD-1:0] s1_data;

  state_e             state_q, state_d, eff_state;
  logic [15:0]        dec_cnt_q, dec_cnt_d;
  logic [15:0]        dec_n_q, dec_n_d;
  logic [15:0]        dec_n_cfg;
  logic [POS_WD-1:0]  w_prev_q, w_prev_d;
  logic [POS_WD-1:0]  w_cur, x_cur, delta, abs_delta;
  logic [DATA_WD-1:0] kept_word;
  logic               first_word, run_word, idle_drop;
  logic               keep, step_err;

  logic               push, push_ovf, flush_done;
  logic [SkidWd-1:0]  push_data, skid_out;
  logic               word_inc;
  logic [1:0]         drop_inc;
  logic [CNT_WD-1:0]  drop_add;

  // sop in the same S1 cycle takes effect before the word is classified.
  assign eff_state  = s1_sop ? StAlign : state_q;
  assign first_word = s1_vld && (eff_state == StAlign);
  assign run_word   = s1_vld && (eff_state == StRun);
  assign idle_drop  = s1_vld && ((eff_state == StIdle) || (eff_state == StFlush));
  assign dec_n_cfg  = (cfg_dec_num == 16'd0) ? 16'd1 : cfg_dec_num;

  assign w_cur      = s1_data[W_LSB +: POS_WD];
  assign x_cur      = s1_data[X_LSB +: POS_WD];
  assign kept_word  = {w_cur, x_cur};
  // Modular difference read as signed; magnitude of the most negative value
  // still comes out right as an unsigned number.
  assign delta      = w_cur - w_prev_q;
  assign abs_delta  = delta[POS_WD-1] ? (~delta + 1'b1) : delta;

  // Keep/step decision and decimation bookkeeping for the word in S1.
  always_comb begin
    dec_cnt_d = dec_cnt_q;
    dec_n_d   = dec_n_q;
    w_prev_d  = w_prev_q;
    keep      = 1'b0;
    step_err  = 1'b0;
    if (s1_sop) begin
      dec_cnt_d = 16'd0;
    end
    if (first_word) begin
      keep      = 1'b1;
      w_prev_d  = w_cur;
      dec_n_d   = dec_n_cfg;
      dec_cnt_d = (dec_n_cfg == 16'd1) ? 16'd0 : 16'd1;
    end else if (run_word) begin
      keep     = (dec_cnt_q == 16'd0);
      step_err = (abs_delta > cfg_max_step);
      w_prev_d = w_cur;
      // A new decimation factor is picked up only at the wrap.
      if (dec_cnt_q >= dec_n_q - 16'd1) begin
        dec_cnt_d = 16'd0;
        dec_n_d   = dec_n_cfg;
      end else begin
        dec_cnt_d = dec_cnt_q + 16'd1;
      end
    end
  end

`ifdef AURORA_ENC_UNPACK_TLAST_EN
  logic               hold_vld_q, hold_vld_d;
  logic [DATA_WD-1:0] hold_data_q, hold_data_d;
  logic               rel_flush;

  // Held word leaves with tlast once the scan has ended, or without tlast
  // when displaced by the next kept word.
  always_comb begin
    rel_flush   = hold_vld_q && (state_q == StFlush);
    push        = rel_flush || (keep && hold_vld_q);
    push_data   = {rel_flush, hold_data_q};
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    if (keep) begin
      hold_vld_d  = 1'b1;
      hold_data_d = kept_word;
    end else if (rel_flush) begin
      hold_vld_d  = 1'b0;
    end
    flush_done  = !m_axis_tvalid && !hold_vld_q;
  end

  // Holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign m_axis_tdata = skid_out[DATA_WD-1:0];
  assign m_axis_tlast = skid_out[DATA_WD];
`else
  // Kept words go straight to the skid buffer.
  always_comb begin
    push       = keep;
    push_data  = kept_word;
    flush_done = !m_axis_tvalid;
  end

  assign m_axis_tdata = skid_out;
  assign m_axis_tlast = 1'b0;
`endif

  // Scan FSM next state; eop is honoured after the same-cycle word.
  always_comb begin
    state_d = eff_state;
    case (eff_state)
      StIdle:  state_d = StIdle;
      StAlign: begin
        if (s1_eop) begin
          state_d = StFlush;
        end else if (s1_vld) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (s1_eop) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (flush_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // S1 register and scan state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_sop    <= 1'b0;
      s1_eop    <= 1'b0;
      s1_data   <= '0;
      state_q   <= StIdle;
      dec_cnt_q <= 16'd0;
      dec_n_q   <= 16'd1;
      w_prev_q  <= '0;
    end else begin
      s1_vld    <= enc_vld;
      s1_sop    <= enc_sop;
      s1_eop    <= enc_eop;
      s1_data   <= enc_data;
      state_q   <= state_d;
      dec_cnt_q <= dec_cnt_d;
      dec_n_q   <= dec_n_d;
      w_prev_q  <= w_prev_d;
    end
  end

  aurora_enc_skid_buf #(
    .WIDTH (SkidWd)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .push_ovf  (push_ovf),
    .out_data  (skid_out),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

  assign busy     = (state_q != StIdle);
  assign word_inc = push && !push_ovf;
  assign drop_inc = {1'b0, idle_drop} + {1'b0, push_ovf};
  assign drop_add = CNT_WD'(drop_inc);

  // Saturating statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt     <= '0;
      step_err_cnt <= '0;
      drop_cnt     <= '0;
    end else if (cfg_clr) begin
      word_cnt     <= '0;
      step_err_cnt <= '0;
      drop_cnt     <= '0;
    end else begin
      if (word_inc && (word_cnt != '1)) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (step_err && (step_err_cnt != '1)) begin
        step_err_cnt <= step_err_cnt + 1'b1;
      end
      if (drop_inc != 2'd0) begin
        drop_cnt <= (drop_cnt > ~drop_add) ? '1 : drop_cnt + drop_add;
      end
    end
  end

endmodule

// File: tb/tb_aurora_enc_unpack.sv
// Self-checking bench for aurora_enc_unpack: directed scenarios plus random
// scans, checked against a word-level scan model kept in the bench.
module tb_aurora_enc_unpack;

  logic        clk, rst, cfg_clr;
  logic [15:0] cfg_dec_num;
  logic [31:0] cfg_max_step;
  logic        enc_sop, enc_eop, enc_vld;
  logic [63:0] enc_data;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, busy;
  logic [31:0] word_cnt, step_err_cnt, drop_cnt;

  aurora_enc_unpack dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_clr       (cfg_clr),
    .cfg_dec_num   (cfg_dec_num),
    .cfg_max_step  (cfg_max_step),
    .enc_sop       (enc_sop),
    .enc_eop       (enc_eop),
    .enc_vld       (enc_vld),
    .enc_data      (enc_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .word_cnt      (word_cnt),
    .step_err_cnt  (step_err_cnt),
    .drop_cnt      (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int n_out = 0;
  int first_out_cyc = -1;

  // Word-level scan model: words are numbered from sop, 1 of N kept.
  logic [63:0] exp_q[$];
  bit          m_in_scan = 0;
  int          m_k = 0;
  int          m_n = 1;
  logic [31:0] m_wprev = '0;
  logic [31:0] m_max = '0;
  int          m_words = 0, m_step = 0, m_drop = 0;
  bit          m_bp = 0;   // downstream stalled: only two outputs fit

  function automatic void model_apply(bit sop, bit eop, bit vld, logic [63:0] d);
    logic [31:0] w;
    int signed   sd;
    longint      ad;
    w = d[63:32];
    if (sop) begin
      m_in_scan = 1;
      m_k = 0;
    end
    if (vld) begin
      if (!m_in_scan) begin
        m_drop++;
      end else begin
        if (m_k > 0) begin
          sd = $signed(w - m_wprev);
          ad = (sd < 0) ? -longint'(sd) : longint'(sd);
          if (ad > longint'(m_max)) m_step++;
        end
        m_wprev = w;
        if (m_k % m_n == 0) begin
          if (m_bp && exp_q.size() >= 2) m_drop++;
          else begin
            exp_q.push_back(d);
            m_words++;
          end
        end
        m_k++;
      end
    end
    if (eop) m_in_scan = 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every handshake must match the model's next sample.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected: got %h, required no output", m_axis_tdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (m_axis_tdata !== e) begin
          fails++;
          $display("FAIL out_data: got %h, required %h", m_axis_tdata, e);
        end
      end
      checks++;
      if (m_axis_tlast !== 1'b0) begin
        fails++;
        $display("FAIL out_tlast: got %b, required 0", m_axis_tlast);
      end
      n_out++;
      if (first_out_cyc < 0) first_out_cyc = cyc;
    end
  end

  task automatic drive(input bit sop, input bit eop, input bit vld, input logic [63:0] d);
    @(posedge clk);
    #1;
    enc_sop  = sop;
    enc_eop  = eop;
    enc_vld  = vld;
    enc_data = vld ? d : 64'h0;
    model_apply(sop, eop, vld, d);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 64'h0);
  endtask

  task automatic clear_stats();
    drive(0, 0, 0, 64'h0);
    cfg_clr = 1'b1;
    @(posedge clk);
    #1;
    cfg_clr = 1'b0;
    m_words = 0;
    m_step  = 0;
    m_drop  = 0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy && !m_axis_tvalid) done = 1;
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL %s_drain: busy=%b tvalid=%b, required busy=0 tvalid=0", name, busy,
               m_axis_tvalid);
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_outstanding: got %0d missing outputs, required 0", name, exp_q.size());
    end
  endtask

  task automatic set_cfg(input int n, input int mx);
    cfg_dec_num  = 16'(n);
    cfg_max_step = 32'(mx);
    m_n   = (n == 0) ? 1 : n;
    m_max = 32'(mx);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || m_axis_tdata !== 64'h0 ||
        m_axis_tlast !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got tvalid=%b busy=%b tdata=%h tlast=%b, required all 0",
               m_axis_tvalid, busy, m_axis_tdata, m_axis_tlast);
    end
    checks++;
    if (word_cnt !== 32'd0 || step_err_cnt !== 32'd0 || drop_cnt !== 32'd0) begin
      fails++;
      $display("FAIL reset_counters: got %0d/%0d/%0d, required 0/0/0", word_cnt, step_err_cnt,
               drop_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int vld_cyc;
    set_cfg(1, 4);
    clear_stats();
    drive(1, 0, 0, 64'h0);
    first_out_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, {32'(100 + i), $urandom});
      if (i == 0) vld_cyc = cyc;
    end
    drive(0, 1, 0, 64'h0);
    idle(2);
    wait_idle("basic");
    checks++;
    if (first_out_cyc - vld_cyc != 2) begin
      fails++;
      $display("FAIL basic_latency: got %0d cycles, required 2", first_out_cyc - vld_cyc);
    end
    checks++;
    if (word_cnt !== 32'd8 || step_err_cnt !== 32'd0) begin
      fails++;
      $display("FAIL basic_counters: got word=%0d step=%0d, required word=8 step=0", word_cnt,
               step_err_cnt);
    end
  endtask

  task automatic test_decimation();
    int n0;
    set_cfg(3, 100);
    clear_stats();
    n0 = n_out;
    drive(1, 0, 0, 64'h0);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, {32'(i), $urandom});
    drive(0, 1, 0, 64'h0);
    idle(2);
    wait_idle("dec");
    checks++;
    if (word_cnt !== 32'd4 || n_out - n0 != 4) begin
      fails++;
      $display("FAIL dec_count: got word=%0d outputs=%0d, required 4/4", word_cnt, n_out - n0);
    end
  endtask

  task automatic test_wrap_step();
    set_cfg(1, 2);
    clear_stats();
    drive(1, 0, 1, {32'hFFFF_FFFE, $urandom});
    drive(0, 0, 1, {32'hFFFF_FFFF, $urandom});
    drive(0, 0, 1, {32'h0000_0001, $urandom});
    idle(3);
    checks++;
    if (step_err_cnt !== 32'd0) begin
      fails++;
      $display("FAIL wrap_no_err: got %0d, required 0", step_err_cnt);
    end
    drive(0, 0, 1, {32'h0000_0010, $urandom});
    idle(3);
    checks++;
    if (step_err_cnt !== 32'd1) begin
      fails++;
      $display("FAIL wrap_err: got %0d, required 1", step_err_cnt);
    end
    drive(0, 1, 0, 64'h0);
    idle(2);
    wait_idle("wrap");
  endtask

  task automatic test_overflow();
    set_cfg(1, 1000);
    clear_stats();
    m_axis_tready = 1'b0;
    m_bp = 1;
    drive(1, 0, 0, 64'h0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, {32'(500 + i), $urandom});
    drive(0, 1, 0, 64'h0);
    idle(3);
    checks++;
    if (drop_cnt !== 32'd3 || word_cnt !== 32'd2 || m_axis_tvalid !== 1'b1) begin
      fails++;
      $display("FAIL ovf_counters: got drop=%0d word=%0d tvalid=%b, required 3/2/1", drop_cnt,
               word_cnt, m_axis_tvalid);
    end
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL ovf_flush_hold: got busy=%b, required 1", busy);
    end
    m_axis_tready = 1'b1;
    m_bp = 0;
    wait_idle("ovf");
  endtask

  task automatic test_boundaries();
    int n0;
    set_cfg(1, 1000);
    clear_stats();
    n0 = n_out;
    for (int i = 0; i < 3; i++) drive(0, 0, 1, {$urandom, $urandom});
    drive(1, 0, 0, 64'h0);
    drive(0, 0, 1, {32'd7, $urandom});
    drive(0, 0, 1, {32'd8, $urandom});
    drive(0, 1, 1, {32'd9, $urandom});
    idle(2);
    wait_idle("bound");
    checks++;
    if (drop_cnt !== 32'd3 || n_out - n0 != 3 || word_cnt !== 32'd3) begin
      fails++;
      $display("FAIL bound_counts: got drop=%0d outputs=%0d word=%0d, required 3/3/3", drop_cnt,
               n_out - n0, word_cnt);
    end
  endtask

  task automatic test_random();
    int          n, len, mx;
    bit          sop_first, eop_last;
    logic [31:0] w;
    clear_stats();
    for (int s = 0; s < 8; s++) begin
      n  = $urandom_range(0, 4);
      mx = $urandom_range(0, 8);
      set_cfg(n, mx);
      len       = $urandom_range(4, 14);
      w         = $urandom;
      sop_first = 1'($urandom_range(0, 1));
      eop_last  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) drive(0, 0, 1, {$urandom, $urandom});
      if (!sop_first) drive(1, 0, 0, 64'h0);
      for (int i = 0; i < len; i++) begin
        drive(sop_first && i == 0, eop_last && i == len - 1, 1, {w, $urandom});
        if ($urandom_range(0, 3) == 0) idle(1);
        w = w + 32'($urandom_range(0, 24)) - 32'd12;
      end
      if (!eop_last) drive(0, 1, 0, 64'h0);
      idle(2);
      wait_idle("rand");
    end
    checks++;
    if (word_cnt !== 32'(m_words) || step_err_cnt !== 32'(m_step) ||
        drop_cnt !== 32'(m_drop)) begin
      fails++;
      $display("FAIL rand_counters: got %0d/%0d/%0d, required %0d/%0d/%0d", word_cnt,
               step_err_cnt, drop_cnt, m_words, m_step, m_drop);
    end
  endtask

  task automatic test_reset_mid();
    set_cfg(1, 1000);
    clear_stats();
    m_axis_tready = 1'b0;
    drive(1, 0, 0, 64'h0);
    drive(0, 0, 1, {32'd1, $urandom});
    drive(0, 0, 1, {32'd2, $urandom});
    idle(3);
    checks++;
    if (m_axis_tvalid !== 1'b1 || word_cnt !== 32'd2) begin
      fails++;
      $display("FAIL rstmid_pre: got tvalid=%b word=%0d, required 1/2", m_axis_tvalid, word_cnt);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || m_axis_tlast !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_outputs: got tvalid=%b busy=%b tlast=%b, required 0/0/0",
               m_axis_tvalid, busy, m_axis_tlast);
    end
    checks++;
    if (word_cnt !== 32'd0 || step_err_cnt !== 32'd0 || drop_cnt !== 32'd0) begin
      fails++;
      $display("FAIL rstmid_counters: got %0d/%0d/%0d, required 0/0/0", word_cnt, step_err_cnt,
               drop_cnt);
    end
    exp_q.delete();
    m_in_scan = 0;
    m_words = 0;
    m_step = 0;
    m_drop = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_axis_tready = 1'b1;
    idle(4);
    wait_idle("rstmid");
  endtask

  initial begin
    rst           = 1'b1;
    cfg_clr       = 1'b0;
    cfg_dec_num   = 16'd1;
    cfg_max_step  = 32'd0;
    enc_sop       = 1'b0;
    enc_eop       = 1'b0;
    enc_vld       = 1'b0;
    enc_data      = 64'h0;
    m_axis_tready = 1'b1;
    test_reset();
    test_basic();
    test_decimation();
    test_wrap_step();
    test_overflow();
    test_boundaries();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
